oven_sequencer: RTL

//  Parametrised multi-stage oven controller FSM; successor to the single-stage temp/timer flow.

---
 rtl/oven_pkg.sv | 33 +++
 rtl/oven_bin2bcd.sv | 25 ++
 rtl/oven_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/oven_pkg.sv
// Shared types and display codes for the multi-stage oven controller.
package oven_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_TEMP,
    S_SET_TIME,
    S_COOK,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam int unsigned MAX_STAGES = 8;
  localparam int unsigned TEMP_W     = 10;
  localparam int unsigned DUR_W      = 13;

  typedef logic [TEMP_W-1:0] temp_t;
  typedef logic [DUR_W-1:0]  dur_t;

  localparam logic [3:0] BLANK  = 4'd10;
  localparam logic [3:0] P_CODE = 4'd11;
  localparam logic [3:0] E_CODE = 4'd12;
  localparam logic [3:0] N_CODE = 4'd13;
  localparam logic [3:0] D_CODE = 4'd14;

  // One saturating step up or down; limits are checked before the add/sub so nothing wraps.
  function automatic dur_t sat_step(input dur_t v, input dur_t step, input dur_t lo,
                                    input dur_t hi, input logic up);
    if (up) return (v > hi - step) ? hi : v + step;
    else    return (v < lo + step) ? lo : v - step;
  endfunction

endpackage

// File: rtl/oven_bin2bcd.sv
// Binary to four BCD digits; mmss=1 splits seconds into mm:ss first.
module oven_bin2bcd
  import oven_pkg::*;
(
  input  logic [DUR_W-1:0] value,
  input  logic             mmss,
  output logic [15:0]      digits
);

  dur_t mins;
  dur_t secs;

  always_comb begin
    mins = value / dur_t'(60);
    secs = value % dur_t'(60);
    if (mmss) begin
      digits = {4'(mins / dur_t'(10)), 4'(mins % dur_t'(10)),
                4'(secs / dur_t'(10)), 4'(secs % dur_t'(10))};
    end else begin
      digits = {4'(value / dur_t'(1000)), 4'((value / dur_t'(100)) % dur_t'(10)),
                4'((value / dur_t'(10)) % dur_t'(10)), 4'(value % dur_t'(10))};
    end
  end

endmodule

// File: rtl/oven_sequencer.sv
// Multi-stage oven controller: programs (temp, duration) stages, then cooks them in order.
module oven_sequencer
  import oven_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned TEMP_MIN   = 100,
  parameter int unsigned TEMP_MAX   = 550,
  parameter int unsigned TEMP_STEP  = 5,
  parameter int unsigned TIME_STEP  = 10,
  parameter int unsigned MAX_SEC    = 5999,
  parameter int unsigned DONE_SEC   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick1Hz,
  input  logic        powerOn,
  input  logic        btnInc,
  input  logic        btnDec,
  input  logic        btnNext,
  input  logic        btnStart,
  input  logic        btnCancel,
  input  logic [15:0] todDigits,
  output logic [23:0] digitOut,
  output logic [2:0]  stageIdx,
  output logic        heating,
  output logic        done
);

  localparam temp_t      T_MIN    = temp_t'(TEMP_MIN);
  localparam dur_t       TS       = dur_t'(TEMP_STEP);
  localparam dur_t       TLO      = dur_t'(TEMP_MIN);
  localparam dur_t       THI      = dur_t'(TEMP_MAX);
  localparam dur_t       DS       = dur_t'(TIME_STEP);
  localparam dur_t       DHI      = dur_t'(MAX_SEC);
  localparam logic [2:0] LAST_IDX = 3'(NUM_STAGES - 1);
  localparam logic [7:0] DONE_CNT = 8'(DONE_SEC);

  state_t     state, state_n;
  temp_t      temps   [MAX_STAGES];
  temp_t      temps_n [MAX_STAGES];
  dur_t       durs    [MAX_STAGES];
  dur_t       durs_n  [MAX_STAGES];
  logic [2:0] stage_idx, idx_n;
  logic [3:0] num_prog, num_n;
  dur_t       remaining, rem_n;
  logic [7:0] done_cnt, dcnt_n;
  logic       blink, blink_n;

  logic       nxt_found;
  logic [2:0] nxt_stage;

  logic [23:0] digits_d;
  logic [3:0]  stage_digit;
  dur_t        temp_val, time_val;
  logic [15:0] temp_bcd, time_bcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stage_idx <= '0;
      num_prog  <= '0;
      remaining <= '0;
      done_cnt  <= '0;
      blink     <= 1'b0;
      for (int unsigned i = 0; i < MAX_STAGES; i++) begin
        temps[i] <= T_MIN;
        durs[i]  <= '0;
      end
    end else begin
      state     <= state_n;
      stage_idx <= idx_n;
      num_prog  <= num_n;
      remaining <= rem_n;
      done_cnt  <= dcnt_n;
      blink     <= blink_n;
      temps     <= temps_n;
      durs      <= durs_n;
    end
  end

  // Next programmed stage after the current one that actually has time on it.
  always_comb begin
    nxt_found = 1'b0;
    nxt_stage = '0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      if (!nxt_found && 4'(i) > {1'b0, stage_idx} && 4'(i) < num_prog && durs[i] != '0) begin
        nxt_found = 1'b1;
        nxt_stage = 3'(i);
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = stage_idx;
    num_n   = num_prog;
    rem_n   = remaining;
    dcnt_n  = done_cnt;
    blink_n = blink;
    temps_n = temps;
    durs_n  = durs;
    if (!powerOn || btnCancel) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_SET_TEMP;
          idx_n   = '0;
          num_n   = '0;
        end
        S_SET_TEMP, S_SET_TIME: begin
          if (btnStart) begin
            if (durs[0] != '0) begin
              num_n   = {1'b0, stage_idx} + 4'd1;
              idx_n   = '0;
              rem_n   = durs[0];
              state_n = S_COOK;
            end
          end else if (btnNext) begin
            if (state == S_SET_TEMP) begin
              state_n = S_SET_TIME;
            end else begin
              num_n = {1'b0, stage_idx} + 4'd1;
              if (stage_idx < LAST_IDX) begin
                idx_n   = stage_idx + 3'd1;
                state_n = S_SET_TEMP;
              end
            end
          end else if (btnInc ^ btnDec) begin
            if (state == S_SET_TEMP)
              temps_n[stage_idx] = temp_t'(sat_step(dur_t'(temps[stage_idx]), TS, TLO, THI, btnInc));
            else
              durs_n[stage_idx] = sat_step(durs[stage_idx], DS, '0, DHI, btnInc);
          end
        end
        S_COOK: begin
          if (btnStart) begin
            state_n = S_PAUSE;
          end else if (tick1Hz) begin
            if (remaining > dur_t'(1)) begin
              rem_n = remaining - dur_t'(1);
            end else if (nxt_found) begin
              idx_n = nxt_stage;
              rem_n = durs[nxt_stage];
            end else begin
              state_n = S_DONE;
              dcnt_n  = '0;
              blink_n = 1'b1;
            end
          end
        end
        S_PAUSE: if (btnStart) state_n = S_COOK;
        S_DONE: begin
          if (tick1Hz) begin
            dcnt_n  = done_cnt + 8'd1;
            blink_n = ~blink;
            if (dcnt_n == DONE_CNT) state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Display decodes the post-edge values so outputs change on the same edge as the state.
  assign temp_val = dur_t'(temps_n[idx_n]);
  assign time_val = (state_n == S_PAUSE) ? rem_n : durs_n[idx_n];

  oven_bin2bcd u_temp_bcd (.value(temp_val), .mmss(1'b0), .digits(temp_bcd));
  oven_bin2bcd u_time_bcd (.value(time_val), .mmss(1'b1), .digits(time_bcd));

  always_comb begin
    digits_d    = {6{BLANK}};
    stage_digit = {1'b0, idx_n} + 4'd1;
    case (state_n)
      S_IDLE: digits_d[15:0] = todDigits;
      S_SET_TEMP, S_COOK: begin
        digits_d[23:20] = stage_digit;
        digits_d[15:12] = (temp_bcd[15:12] == 4'd0) ? BLANK : temp_bcd[15:12];
        digits_d[11:0]  = temp_bcd[11:0];
      end
      S_SET_TIME, S_PAUSE: begin
        digits_d[23:20] = stage_digit;
        digits_d[15:0]  = time_bcd;
        if (state_n == S_PAUSE) digits_d[19:16] = P_CODE;
      end
      S_DONE: if (blink_n) digits_d[11:0] = {E_CODE, N_CODE, D_CODE};
      default: digits_d = {6{BLANK}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digitOut <= {6{BLANK}};
      stageIdx <= '0;
      heating  <= 1'b0;
      done     <= 1'b0;
    end else begin
      digitOut <= digits_d;
      stageIdx <= idx_n;
      heating  <= (state_n == S_COOK);
      done     <= (state_n == S_DONE);
    end
  end

endmodule
